mips_cpu_regfile_param: RTL and testbench

Parametrised successor to the CPU general-purpose register file. It has configurable data width, depth and read-port count, and a post-reset clearing sweep, so storage can map to RAM. It also has a per-register busy scoreboard for multi-cycle producers (loads, MULT/DIV writeback) and an optional write-to-read bypass. It sits between decode (read ports, reservations) and writeback (write port), and exports `register_v0` to the testbench interface.

---
 rtl/mips_cpu_regfile_param.sv | 122 ++++++++++++
 tb/tb_mips_cpu_regfile_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_regfile_param.sv
// mips_cpu_regfile_param
// Parametrised general-purpose register file with a post-reset clearing
// sweep, a per-register busy scoreboard for multi-cycle producers, and an
// optional write-to-read bypass selected by the REGFILE_BYPASS_EN macro.
// Entry 0 is hardwired to zero and can never be reserved.
// Storage has no reset of its own: it is zeroed by the sweep so that it
// can map onto a RAM macro.
module mips_cpu_regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2,
  parameter int V0_IDX = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     reserve,
  input  logic [ADDR_W-1:0]        res_addr,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  output logic [DATA_W-1:0]        register_v0,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] V0_A = ADDR_W'(V0_IDX);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [DEPTH-1:0]    busy;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                run;
  logic                wrOk;
  logic                resOk;

  assign run   = (state == RUN);
  assign ready = run;
  assign wrOk  = run && write && (wr_addr != '0);
  assign resOk = run && reserve && (res_addr != '0);

  // Sequencer: sweep pointer through every entry, then run; tracks busy bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          busy <= '0;
          if (ptr == LAST) begin
            state <= RUN;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        RUN: begin
          // a reservation on the same edge as a write overrides the clear
          if (wrOk) begin
            busy[wr_addr] <= 1'b0;
          end
          if (resOk) begin
            busy[res_addr] <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= '0;
        end
      endcase
    end
  end

  // Storage write: zero one entry per cycle while clearing, else the write port
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[ptr] <= '0;
    end else if (wrOk) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Exported v0 follows stored contents only, never the bypass
  assign register_v0 = (run && (V0_A != '0)) ? mem[V0_A] : '0;

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    // Read port: zero while clearing or for entry 0, else stored (or bypassed) data
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (run && (addr != '0)) begin
        data = mem[addr];
        bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
        if (write && (wr_addr == addr)) begin
          data = wr_data;
        end
`endif
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = bsy;
  end

endmodule

// File: tb/tb_mips_cpu_regfile_param.sv
// Directed testbench for mips_cpu_regfile_param: a default instance and a
// small instance with ADDR_W=3, N_RD=3.
module tb_mips_cpu_regfile_param;

  logic        clk;
  int          vectors;
  int          miscompares;

  // default instance signals
  logic        reset_n;
  logic        write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        reserve;
  logic [4:0]  res_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [31:0] register_v0;
  logic        ready;

  // small instance signals
  logic        reset1_n;
  logic        write1;
  logic [2:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic        reserve1;
  logic [2:0]  res_addr1;
  logic [8:0]  rd_addr1;
  logic [95:0] rd_data1;
  logic [2:0]  rd_busy1;
  logic [31:0] register_v0_1;
  logic        ready1;

  mips_cpu_regfile_param u0 (
    .clk(clk), .reset_n(reset_n), .write(write), .wr_addr(wr_addr),
    .wr_data(wr_data), .reserve(reserve), .res_addr(res_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .register_v0(register_v0), .ready(ready)
  );

  mips_cpu_regfile_param #(.DATA_W(32), .ADDR_W(3), .N_RD(3), .V0_IDX(2)) u1 (
    .clk(clk), .reset_n(reset1_n), .write(write1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .reserve(reserve1), .res_addr(res_addr1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .register_v0(register_v0_1), .ready(ready1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison: count it, and report observed/expected on a miscompare
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b0;
    write    = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'h11111111;
    reserve  = 1'b1;
    res_addr = 5'd5;
    rd_addr  = {5'd5, 5'd2};
    reset1_n  = 1'b0;
    write1    = 1'b0;
    wr_addr1  = '0;
    wr_data1  = '0;
    reserve1  = 1'b0;
    res_addr1 = '0;
    rd_addr1  = '0;

    // reset held for three cycles with write/reserve attempts pending
    #1;
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_rd_data", rd_data, 64'd0);
    checkOutput("rst_rd_busy", 64'(rd_busy), 64'd0);
    checkOutput("rst_v0", 64'(register_v0), 64'd0);
    repeat (3) applyStimulus();
    reset_n = 1'b1;

    // clear sweep: ready rises exactly on the 32nd edge
    for (int i = 1; i <= 32; i++) begin
      applyStimulus();
      if (i == 16) begin
        checkOutput("clear_rd_data", rd_data, 64'd0);
        checkOutput("clear_rd_busy", 64'(rd_busy), 64'd0);
      end
      checkOutput($sformatf("clear_ready_e%0d", i), 64'(ready), 64'(i == 32));
    end
    write   = 1'b0;
    reserve = 1'b0;

    // every entry zero, write/reserve during clear had no effect
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      checkOutput($sformatf("zero_p0_r%0d", a), {32'd0, rd_data[31:0]}, 64'd0);
      checkOutput($sformatf("zero_p1_r%0d", 31 - a), {32'd0, rd_data[63:32]}, 64'd0);
      checkOutput($sformatf("zero_busy_%0d", a), 64'(rd_busy), 64'd0);
    end

    // basic write/read, v0 updates only after the edge
    write = 1'b1; wr_addr = 5'd2; wr_data = 32'hDEADBEEF;
    #1;
    checkOutput("v0_before_edge", 64'(register_v0), 64'd0);
    applyStimulus();
    wr_addr = 5'd5; wr_data = 32'h12345678;
    applyStimulus();
    write = 1'b0;
    rd_addr = {5'd5, 5'd2};
    #1;
    checkOutput("basic_r2", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    checkOutput("basic_r5", {32'd0, rd_data[63:32]}, 64'h12345678);
    checkOutput("basic_v0", 64'(register_v0), 64'hDEADBEEF);

    // zero register: writes and reservations discarded, also not bypassed
    write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    reserve = 1'b1; res_addr = 5'd0;
    rd_addr = {5'd2, 5'd0};
    #1;
    checkOutput("r0_during_write", {32'd0, rd_data[31:0]}, 64'd0);
    applyStimulus();
    write = 1'b0; reserve = 1'b0;
    #1;
    checkOutput("r0_data", {32'd0, rd_data[31:0]}, 64'd0);
    checkOutput("r0_busy", 64'(rd_busy[0]), 64'd0);

    // scoreboard on r7
    rd_addr = {5'd2, 5'd7};
    reserve = 1'b1; res_addr = 5'd7;
    #1;
    checkOutput("r7_busy_before", 64'(rd_busy[0]), 64'd0);
    applyStimulus();
    reserve = 1'b0;
    #1;
    checkOutput("r7_busy_set", 64'(rd_busy), 64'b01);
    write = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
    checkOutput("r7_busy_during_write", 64'(rd_busy[0]), 64'd1);
    applyStimulus();
    write = 1'b0;
    #1;
    checkOutput("r7_busy_cleared", 64'(rd_busy[0]), 64'd0);
    checkOutput("r7_data", {32'd0, rd_data[31:0]}, 64'hA5A5A5A5);
    write = 1'b1; wr_addr = 5'd7; wr_data = 32'h5A5A5A5A;
    reserve = 1'b1; res_addr = 5'd7;
    applyStimulus();
    write = 1'b0; reserve = 1'b0;
    #1;
    checkOutput("r7_same_edge_busy", 64'(rd_busy[0]), 64'd1);
    checkOutput("r7_same_edge_data", {32'd0, rd_data[31:0]}, 64'h5A5A5A5A);

    // bypass behaviour on r3 (busy never bypassed)
    rd_addr = {5'd3, 5'd7};
    write = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("r3_same_cycle", {32'd0, rd_data[63:32]}, 64'hCAFEF00D);
`else
    checkOutput("r3_same_cycle", {32'd0, rd_data[63:32]}, 64'd0);
`endif
    checkOutput("v0_no_bypass", 64'(register_v0), 64'hDEADBEEF);
    applyStimulus();
    write = 1'b0;
    #1;
    checkOutput("r3_next_cycle", {32'd0, rd_data[63:32]}, 64'hCAFEF00D);

    // asynchronous reset mid-run, between edges
    rd_addr = {5'd7, 5'd2};
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_ready", 64'(ready), 64'd0);
    checkOutput("midrst_rd_data", rd_data, 64'd0);
    checkOutput("midrst_rd_busy", 64'(rd_busy), 64'd0);
    checkOutput("midrst_v0", 64'(register_v0), 64'd0);
    applyStimulus();
    reset_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      applyStimulus();
      checkOutput($sformatf("reclear_ready_e%0d", i), 64'(ready), 64'(i == 32));
    end
    #1;
    checkOutput("reclear_r2", {32'd0, rd_data[31:0]}, 64'd0);
    checkOutput("reclear_r7_busy", 64'(rd_busy), 64'd0);
    checkOutput("reclear_v0", 64'(register_v0), 64'd0);
    rd_addr = {5'd3, 5'd5};
    #1;
    checkOutput("reclear_r5_r3", rd_data, 64'd0);

    // small instance: 8-entry clear, three read ports
    #1;
    checkOutput("small_rst_ready", 64'(ready1), 64'd0);
    repeat (3) applyStimulus();
    reset1_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus();
      checkOutput($sformatf("small_ready_e%0d", i), 64'(ready1), 64'(i == 8));
    end
    write1 = 1'b1; wr_addr1 = 3'd2; wr_data1 = 32'h0BADF00D;
    applyStimulus();
    wr_addr1 = 3'd6; wr_data1 = 32'h0000600D;
    reserve1 = 1'b1; res_addr1 = 3'd6;
    applyStimulus();
    write1 = 1'b0; reserve1 = 1'b0;
    rd_addr1 = {3'd0, 3'd6, 3'd2};
    #1;
    checkOutput("small_p0_r2", {32'd0, rd_data1[31:0]}, 64'h0BADF00D);
    checkOutput("small_p1_r6", {32'd0, rd_data1[63:32]}, 64'h0000600D);
    checkOutput("small_p2_r0", {32'd0, rd_data1[95:64]}, 64'd0);
    checkOutput("small_busy", 64'(rd_busy1), 64'b010);
    checkOutput("small_v0", 64'(register_v0_1), 64'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
